// File: rtl/ex_mem_elastic_pipe.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Gates side-effecting control bits on bubbles and resolves the branch-taken condition.
module ex_mem_elastic_pipe #(
    parameter int XLEN     = 64,
    parameter int RADDR_W  = 5,
    parameter int ALUCTL_W = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [XLEN-1:0]     BRANCH,
    input  logic [XLEN-1:0]     ALU_VAL,
    input  logic [XLEN-1:0]     RT_READ,
    input  logic [RADDR_W-1:0]  REG_DESTINATION,
    input  logic [ALUCTL_W-1:0] ALU_CONTROL,
    input  logic                ZERO,
    input  logic                REGWRITE_IN,
    input  logic                MEM2REG_IN,
    input  logic                MEMWRITE_IN,
    input  logic                MEMREAD_IN,
    input  logic                BRANCH_ZERO_IN,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [XLEN-1:0]     BRANCH_OUT,
    output logic [XLEN-1:0]     ALU_VAL_OUT,
    output logic [XLEN-1:0]     RT_READ_OUT,
    output logic [RADDR_W-1:0]  REG_DESTINATION_OUT,
    output logic [ALUCTL_W-1:0] ALU_CONTROL_OUT,
    output logic                ZERO_OUT,
    output logic                MEM2REG_OUT,
    output logic                REGWRITE_OUT,
    output logic                MEMWRITE_OUT,
    output logic                MEMREAD_OUT,
    output logic                BRANCH_ZERO_OUT,
    output logic                BRANCH_TAKEN,
    output logic [1:0]          OCCUPANCY
);

    typedef struct packed {
        logic [XLEN-1:0]     branch;
        logic [XLEN-1:0]     alu_val;
        logic [XLEN-1:0]     rt_read;
        logic [RADDR_W-1:0]  reg_destination;
        logic [ALUCTL_W-1:0] alu_control;
        logic                zero;
        logic                regwrite;
        logic                mem2reg;
        logic                memwrite;
        logic                memread;
        logic                branch_zero;
    } payload_t;

    payload_t head_q;
    payload_t skid_q;
    payload_t in_payload;
    logic     head_valid;
    logic     skid_valid;
    logic     in_fire;
    logic     head_free;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // IN_READY comes straight from the skid valid flop, so OUT_READY never reaches it combinationally.
    assign IN_READY  = ~skid_valid;
    assign in_fire   = IN_VALID & ~skid_valid;
    assign head_free = ~head_valid | OUT_READY;

    assign in_payload = '{
        branch:          BRANCH,
        alu_val:         ALU_VAL,
        rt_read:         RT_READ,
        reg_destination: REG_DESTINATION,
        alu_control:     ALU_CONTROL,
        zero:            ZERO,
        regwrite:        REGWRITE_IN,
        mem2reg:         MEM2REG_IN,
        memwrite:        MEMWRITE_IN,
        memread:         MEMREAD_IN,
        branch_zero:     BRANCH_ZERO_IN
    };

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else if (FLUSH) begin
            // Payload left in place; valid gating hides it.
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (head_free) begin
            if (skid_valid) begin
                head_q     <= skid_q;
                head_valid <= 1'b1;
                skid_valid <= in_fire;
                if (in_fire) begin
                    skid_q <= in_payload;
                end
            end else begin
                head_valid <= in_fire;
                if (in_fire) begin
                    head_q <= in_payload;
                end
            end
        end else if (in_fire) begin
            skid_q     <= in_payload;
            skid_valid <= 1'b1;
        end
    end

    assign OUT_VALID           = head_valid;
    assign BRANCH_OUT          = head_q.branch;
    assign ALU_VAL_OUT         = head_q.alu_val;
    assign RT_READ_OUT         = head_q.rt_read;
    assign REG_DESTINATION_OUT = head_q.reg_destination;
    assign ALU_CONTROL_OUT     = head_q.alu_control;
    assign ZERO_OUT            = head_q.zero;
    assign MEM2REG_OUT         = head_q.mem2reg;
    assign REGWRITE_OUT        = head_valid & head_q.regwrite;
    assign MEMWRITE_OUT        = head_valid & head_q.memwrite;
    assign MEMREAD_OUT         = head_valid & head_q.memread;
    assign BRANCH_ZERO_OUT     = head_valid & head_q.branch_zero;
    assign BRANCH_TAKEN        = head_valid & head_q.branch_zero & head_q.zero;
    assign OCCUPANCY           = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_elastic_pipe.sv
// Bench for ex_mem_elastic_pipe: directed cases plus random traffic against a
// depth-2 FIFO reference model with ready = (entries held < 2).
module tb_ex_mem_elastic_pipe;

    localparam int XLEN     = 64;
    localparam int RADDR_W  = 5;
    localparam int ALUCTL_W = 6;
    localparam int PW       = 3 * XLEN + RADDR_W + ALUCTL_W + 6;
    // Packed payload bit positions (LSB end): bz, memread, memwrite, mem2reg, regwrite, zero
    localparam logic [PW-1:0] GATE_MASK = PW'(6'b010111);

    logic                CLK;
    logic                RESET;
    logic                FLUSH;
    logic                IN_VALID;
    logic                IN_READY;
    logic [XLEN-1:0]     BRANCH;
    logic [XLEN-1:0]     ALU_VAL;
    logic [XLEN-1:0]     RT_READ;
    logic [RADDR_W-1:0]  REG_DESTINATION;
    logic [ALUCTL_W-1:0] ALU_CONTROL;
    logic                ZERO;
    logic                REGWRITE_IN;
    logic                MEM2REG_IN;
    logic                MEMWRITE_IN;
    logic                MEMREAD_IN;
    logic                BRANCH_ZERO_IN;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [XLEN-1:0]     BRANCH_OUT;
    logic [XLEN-1:0]     ALU_VAL_OUT;
    logic [XLEN-1:0]     RT_READ_OUT;
    logic [RADDR_W-1:0]  REG_DESTINATION_OUT;
    logic [ALUCTL_W-1:0] ALU_CONTROL_OUT;
    logic                ZERO_OUT;
    logic                MEM2REG_OUT;
    logic                REGWRITE_OUT;
    logic                MEMWRITE_OUT;
    logic                MEMREAD_OUT;
    logic                BRANCH_ZERO_OUT;
    logic                BRANCH_TAKEN;
    logic [1:0]          OCCUPANCY;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] obs_pl;

    assign {BRANCH, ALU_VAL, RT_READ, REG_DESTINATION, ALU_CONTROL, ZERO,
            REGWRITE_IN, MEM2REG_IN, MEMWRITE_IN, MEMREAD_IN, BRANCH_ZERO_IN} = in_pl;
    assign obs_pl = {BRANCH_OUT, ALU_VAL_OUT, RT_READ_OUT, REG_DESTINATION_OUT, ALU_CONTROL_OUT,
                     ZERO_OUT, REGWRITE_OUT, MEM2REG_OUT, MEMWRITE_OUT, MEMREAD_OUT, BRANCH_ZERO_OUT};

    ex_mem_elastic_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ALUCTL_W(ALUCTL_W)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .BRANCH(BRANCH), .ALU_VAL(ALU_VAL), .RT_READ(RT_READ),
        .REG_DESTINATION(REG_DESTINATION), .ALU_CONTROL(ALU_CONTROL), .ZERO(ZERO),
        .REGWRITE_IN(REGWRITE_IN), .MEM2REG_IN(MEM2REG_IN), .MEMWRITE_IN(MEMWRITE_IN),
        .MEMREAD_IN(MEMREAD_IN), .BRANCH_ZERO_IN(BRANCH_ZERO_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .BRANCH_OUT(BRANCH_OUT), .ALU_VAL_OUT(ALU_VAL_OUT), .RT_READ_OUT(RT_READ_OUT),
        .REG_DESTINATION_OUT(REG_DESTINATION_OUT), .ALU_CONTROL_OUT(ALU_CONTROL_OUT),
        .ZERO_OUT(ZERO_OUT), .MEM2REG_OUT(MEM2REG_OUT), .REGWRITE_OUT(REGWRITE_OUT),
        .MEMWRITE_OUT(MEMWRITE_OUT), .MEMREAD_OUT(MEMREAD_OUT),
        .BRANCH_ZERO_OUT(BRANCH_ZERO_OUT), .BRANCH_TAKEN(BRANCH_TAKEN),
        .OCCUPANCY(OCCUPANCY)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_head;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [XLEN-1:0] br, input logic [XLEN-1:0] alu,
                                           input logic [XLEN-1:0] rt, input logic [RADDR_W-1:0] rd,
                                           input logic [ALUCTL_W-1:0] ctl, input logic zero,
                                           input logic regwrite, input logic mem2reg,
                                           input logic memwrite, input logic memread,
                                           input logic bz);
        return {br, alu, rt, rd, ctl, zero, regwrite, mem2reg, memwrite, memread, bz};
    endfunction

    function automatic logic [PW-1:0] rand_entry();
        return pack({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    RADDR_W'($urandom), ALUCTL_W'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    // Compare every output against the model, which holds the entries in FIFO order.
    task automatic check_outputs(input string tag);
        logic          v;
        logic [PW-1:0] h;
        v = (exp_q.size() > 0);
        h = v ? exp_q[0] : last_head;
        check({tag, ".out_valid"}, 256'(OUT_VALID), 256'(v));
        check({tag, ".payload"}, 256'(obs_pl), 256'(v ? h : (h & ~GATE_MASK)));
        check({tag, ".taken"}, 256'(BRANCH_TAKEN), 256'(v & h[0] & h[5]));
        check({tag, ".in_ready"}, 256'(IN_READY), 256'(exp_q.size() < 2));
        check({tag, ".occupancy"}, 256'(OCCUPANCY), 256'(exp_q.size()));
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic step(input logic v, input logic [PW-1:0] d, input logic ordy,
                        input logic fl, input logic rst, input string tag);
        logic in_fire;
        logic out_fire;
        IN_VALID  = v;
        in_pl     = d;
        OUT_READY = ordy;
        FLUSH     = fl;
        RESET     = rst;
        @(negedge CLK);
        check_outputs(tag);
        in_fire  = v && (exp_q.size() < 2);
        out_fire = ordy && (exp_q.size() > 0);
        @(posedge CLK);
        #1;
        if (rst) begin
            exp_q.delete();
            last_head = '0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (out_fire) void'(exp_q.pop_front());
            if (in_fire) exp_q.push_back(d);
        end
        if (exp_q.size() > 0) last_head = exp_q[0];
    endtask

    // ---------------- stimulus ----------------
    logic [PW-1:0] ea, eb, ec, ex;
    logic          r_v;
    logic [PW-1:0] r_d;
    logic          held;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        last_head = '0;
        RESET     = 1'b1;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        in_pl     = '0;
        @(posedge CLK);
        #1;
        step(0, '0, 0, 0, 1, "reset");
        check("reset.all_zero", 256'(obs_pl), 256'(0));
        check("reset.in_ready", 256'(IN_READY), 256'(1));

        // Single entry, 1-cycle latency, then bubble gating
        ea = pack(64'h0, 64'h1234, 64'h0, 5'd3, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1, ea, 1, 0, 0, "single");
        check("single.alu", 256'(ALU_VAL_OUT), 256'(64'h1234));
        check("single.regwrite", 256'(REGWRITE_OUT), 256'(1));
        check("single.occ", 256'(OCCUPANCY), 256'(1));
        step(0, '0, 1, 0, 0, "single_drain");
        check("single.bubble_valid", 256'(OUT_VALID), 256'(0));
        check("single.bubble_regwrite", 256'(REGWRITE_OUT), 256'(0));

        // Backpressure: A,B fill, C held by EX, then drain in order
        ea = rand_entry(); eb = rand_entry(); ec = rand_entry();
        step(1, ea, 0, 0, 0, "bp_a");
        step(1, eb, 0, 0, 0, "bp_b");
        check("bp.in_ready_low", 256'(IN_READY), 256'(0));
        check("bp.occ_full", 256'(OCCUPANCY), 256'(2));
        step(1, ec, 0, 0, 0, "bp_c_held");
        step(1, ec, 1, 0, 0, "bp_drain_a");
        step(1, ec, 1, 0, 0, "bp_drain_b");
        step(0, '0, 1, 0, 0, "bp_drain_c");
        step(0, '0, 1, 0, 0, "bp_empty");

        // Flush a full buffer with an incoming entry
        ea = rand_entry(); ea[2] = 1'b1;
        eb = rand_entry(); eb[2] = 1'b1;
        ex = rand_entry(); ex[2] = 1'b1;
        step(1, ea, 0, 0, 0, "fl_a");
        step(1, eb, 0, 0, 0, "fl_b");
        step(1, ex, 0, 1, 0, "fl_flush");
        check("flush.out_valid", 256'(OUT_VALID), 256'(0));
        check("flush.occ", 256'(OCCUPANCY), 256'(0));
        check("flush.in_ready", 256'(IN_READY), 256'(1));
        check("flush.memwrite", 256'(MEMWRITE_OUT), 256'(0));
        step(0, '0, 1, 0, 0, "fl_after1");
        step(0, '0, 1, 0, 0, "fl_after2");

        // Branch resolution
        ea = pack(64'h40, 64'h0, 64'h0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1, ea, 1, 0, 0, "br_taken");
        check("branch.taken", 256'(BRANCH_TAKEN), 256'(1));
        check("branch.target", 256'(BRANCH_OUT), 256'(64'h40));
        ea[5] = 1'b0;
        step(1, ea, 1, 0, 0, "br_not_taken");
        check("branch.not_taken", 256'(BRANCH_TAKEN), 256'(0));
        step(0, '0, 1, 0, 0, "br_drain");

        // Reset mid-stream with a full buffer
        step(1, rand_entry(), 0, 0, 0, "rs_a");
        step(1, rand_entry(), 0, 0, 0, "rs_b");
        step(1, rand_entry(), 0, 0, 1, "rs_reset");
        check("midreset.all_zero", 256'(obs_pl), 256'(0));
        check("midreset.flags", 256'({OUT_VALID, BRANCH_TAKEN, OCCUPANCY}), 256'(0));
        check("midreset.in_ready", 256'(IN_READY), 256'(1));

        // Random traffic; EX keeps an unaccepted entry stable until taken
        held = 1'b0;
        r_v  = 1'b0;
        r_d  = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!held) begin
                r_v = ($urandom_range(0, 3) != 0);
                r_d = rand_entry();
            end
            held = r_v && (exp_q.size() >= 2);
            step(r_v, r_d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 999) == 0), "rand");
            if (FLUSH || RESET) held = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_elastic_pipe.md
Name: ex_mem_elastic_pipe

Overview:
Parametrised EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer, so EX can stall or drain independently of MEM. It supports a synchronous flush for branch redirects, gates side-effecting control bits on invalid slots, and resolves the branch-taken condition at the stage boundary. It sits between the ALU/branch-adder outputs and the data-memory stage of the 64-bit datapath.

Parameters:
XLEN, 64, width of branch target, ALU result and store data
RADDR_W, 5, register-destination index width
ALUCTL_W, 6, ALU control field width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
FLUSH  in  1  synchronous kill of all held and incoming entries
IN_VALID  in  1  EX presents a valid entry
IN_READY  out  1  stage can accept (registered: high iff skid empty)
BRANCH  in  XLEN  branch target
ALU_VAL  in  XLEN  ALU result
RT_READ  in  XLEN  store data
REG_DESTINATION  in  RADDR_W  writeback register index
ALU_CONTROL  in  ALUCTL_W  ALU control code
ZERO  in  1  ALU zero flag
REGWRITE_IN, MEM2REG_IN, MEMWRITE_IN, MEMREAD_IN, BRANCH_ZERO_IN  in  1 each  control bits
OUT_VALID  out  1  head entry valid
OUT_READY  in  1  MEM consumes head this cycle when OUT_VALID
BRANCH_OUT, ALU_VAL_OUT, RT_READ_OUT  out  XLEN  head payload
REG_DESTINATION_OUT  out  RADDR_W  head payload
ALU_CONTROL_OUT  out  ALUCTL_W  head payload
ZERO_OUT, MEM2REG_OUT  out  1  head payload
REGWRITE_OUT, MEMWRITE_OUT, MEMREAD_OUT, BRANCH_ZERO_OUT  out  1  head control, forced 0 when !OUT_VALID
BRANCH_TAKEN  out  1  OUT_VALID & BRANCH_ZERO_OUT & ZERO_OUT
OCCUPANCY  out  2  entries held (0..2)

Behaviour:
- One clock, CLK; RESET synchronous, active-high, highest priority.
- Reset: head/skid valid=0, all payload registers 0; hence all outputs 0, IN_READY=1, OCCUPANCY=0.
- Storage: head register (drives outputs) and skid register, each a payload plus valid bit.
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Per cycle (no FLUSH):
  - head empty or out_fire, skid valid: skid->head; in_fire entry (if any) -> skid.
  - head empty or out_fire, skid empty: in_fire entry -> head; otherwise head valid clears.
  - head held (valid & !OUT_READY): in_fire entry -> skid.
- IN_READY = !skid_valid (registered, no combinational path from OUT_READY). Skid is filled only when head is held, so no overflow.
- Latency: 1 cycle IN->OUT when empty. Throughput: 1/cycle with OUT_READY held high. Order is strict FIFO.
- FLUSH: next cycle both valids=0 and OCCUPANCY=0; any same-cycle in_fire entry is discarded; an out_fire in the flush cycle is still consumed by MEM. Payload data is left as is but masked by valid gating. FLUSH together with RESET: reset wins (no observable difference).
- Gating: REGWRITE/MEMWRITE/MEMREAD/BRANCH_ZERO outputs are ANDed with OUT_VALID so a bubble never writes; other payload outputs hold their last value when invalid.
- OCCUPANCY = head_valid + skid_valid; never exceeds 2.
- IN_VALID with IN_READY=0: entry not captured; EX must hold it.

Test Plan:
- Reset then IN_VALID=1, ALU_VAL=64'h1234, REGWRITE_IN=1, OUT_READY=1 -> next cycle OUT_VALID=1, ALU_VAL_OUT=64'h1234, REGWRITE_OUT=1, OCCUPANCY=1. After IN_VALID=0 -> OUT_VALID=0, REGWRITE_OUT=0.
- Stream A,B,C on consecutive cycles with OUT_READY=0 from cycle 1 -> A in head, B in skid, IN_READY=0 from cycle 3, C held by EX. Then OUT_READY=1 -> outputs A,B,C in order, no drop, no duplicate.
- Full (OCCUPANCY=2), assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, OCCUPANCY=0, IN_READY=1, MEMWRITE_OUT=0; the incoming entry never appears.
- Entry with BRANCH_ZERO_IN=1, ZERO=1, BRANCH=64'h40 -> BRANCH_TAKEN=1, BRANCH_OUT=64'h40. Same with ZERO=0 -> BRANCH_TAKEN=0.
- Full buffer, RESET for 1 cycle mid-stream -> all outputs 0, IN_READY=1 on the following cycle.
- Random IN_VALID/OUT_READY for 10k cycles against a scoreboard FIFO model -> in-order delivery, OCCUPANCY<=2, IN_READY==!skid_valid every cycle.
